// File: rtl/text_stream_writer.sv
// Purpose: terminal-style character stream to 80x40 text cell writes, tracking the cursor.
// Latency: control chars update the cursor 1 cycle after accept; a printable write issues 1 cycle after accept.
// Backpressure: o_ready is low while a write or clear is outstanding; each write is held until i_ack.
module text_stream_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 40,
    parameter int AW   = 12
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          i_valid,
    input  logic [7:0]    i_char,
    output logic          o_ready,
    output logic          o_wr,
    output logic [AW-1:0] o_addr,
    output logic [7:0]    o_data,
    input  logic          i_ack,
    output logic [6:0]    o_col,
    output logic [5:0]    o_row,
    output logic          o_clearing
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);
    localparam logic [6:0]    COL_MAX   = 7'(COLS - 1);
    localparam logic [5:0]    ROW_MAX   = 6'(ROWS - 1);

    state_t        state, state_nx;
    logic          run;
    logic          wr_nx, clr_nx;
    logic [AW-1:0] addr_nx, cell_addr;
    logic [7:0]    data_nx;
    logic [6:0]    col_nx;
    logic [5:0]    row_nx, row_inc;
    logic          accept, printable;

    // Ready only after the first edge following reset release, and only when idle.
    assign o_ready   = run && (state == IDLE);
    assign accept    = i_valid && o_ready;
    assign printable = (i_char >= 8'h20) && (i_char != 8'h7F);
    assign cell_addr = AW'(o_row) * AW'(COLS) + AW'(o_col);
    assign row_inc   = (o_row == ROW_MAX) ? 6'd0 : o_row + 6'd1;

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nx = state;
        wr_nx    = o_wr;
        clr_nx   = o_clearing;
        addr_nx  = o_addr;
        data_nx  = o_data;
        col_nx   = o_col;
        row_nx   = o_row;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        addr_nx  = cell_addr;
                        data_nx  = i_char;
                        wr_nx    = 1'b1;
                        state_nx = WRITE;
                    end else if (i_char == 8'h0D) begin
                        col_nx = 7'd0;
                    end else if (i_char == 8'h0A) begin
                        row_nx = row_inc;
                    end else if (i_char == 8'h08) begin
                        if (o_col != 7'd0) col_nx = o_col - 7'd1;
                    end else if (i_char == 8'h0C) begin
                        addr_nx  = '0;
                        data_nx  = 8'h20;
                        wr_nx    = 1'b1;
                        clr_nx   = 1'b1;
                        state_nx = CLEAR;
                    end
                end
            end
            WRITE: begin
                if (i_ack) begin
                    wr_nx    = 1'b0;
                    state_nx = IDLE;
                    if (o_col == COL_MAX) begin
                        col_nx = 7'd0;
                        row_nx = row_inc;
                    end else begin
                        col_nx = o_col + 7'd1;
                    end
                end
            end
            CLEAR: begin
                if (i_ack) begin
                    if (o_addr == LAST_ADDR) begin
                        wr_nx    = 1'b0;
                        clr_nx   = 1'b0;
                        col_nx   = 7'd0;
                        row_nx   = 6'd0;
                        state_nx = IDLE;
                    end else begin
                        addr_nx = o_addr + AW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset abandons any write or clear in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            run        <= 1'b0;
            o_wr       <= 1'b0;
            o_clearing <= 1'b0;
            o_addr     <= '0;
            o_data     <= 8'h00;
            o_col      <= 7'd0;
            o_row      <= 6'd0;
        end else begin
            state      <= state_nx;
            run        <= 1'b1;
            o_wr       <= wr_nx;
            o_clearing <= clr_nx;
            o_addr     <= addr_nx;
            o_data     <= data_nx;
            o_col      <= col_nx;
            o_row      <= row_nx;
        end
    end

endmodule
